pipe_adder: RTL and testbench

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 121 ++++++++++++
 tb/tb_pipe_adder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// Segmented, carry-pipelined adder/subtractor with valid/ready handshake and a global stall.
// Define PIPE_ADDER_OVF_EN to add the signed overflow output.
module pipe_adder #(
  parameter int unsigned Width  = 8,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int unsigned SliceW = Width / Stages;
  localparam int unsigned Last   = Stages - 1;

  // Per-segment state: operands travel along (B already conditionally inverted),
  // the result word fills in one slice per segment.
  logic [Width-1:0] a_q   [Stages];
  logic [Width-1:0] a_d   [Stages];
  logic [Width-1:0] b_q   [Stages];
  logic [Width-1:0] b_d   [Stages];
  logic [Width-1:0] res_q [Stages];
  logic [Width-1:0] res_d [Stages];
  logic [Stages-1:0] carry_q, carry_d;
  logic [Stages-1:0] valid_q, valid_d;

  // Segment inputs: segment 0 takes the ports, segment k takes segment k-1's registers.
  logic [Width-1:0]  s_a   [Stages];
  logic [Width-1:0]  s_b   [Stages];
  logic [Width-1:0]  s_r   [Stages];
  logic [Stages-1:0] s_c;
  logic [Stages-1:0] s_v;
  logic [SliceW:0]   sum_c [Stages];

  logic adv;

  assign adv     = !valid_o || ready_i;
  assign ready_o = adv;

  always_comb begin
    s_a[0] = a_i;
    s_b[0] = sub_i ? ~b_i : b_i;
    s_r[0] = '0;
    s_c[0] = sub_i;
    s_v[0] = valid_i;
    for (int k = 1; k < Stages; k++) begin
      s_a[k] = a_q[k-1];
      s_b[k] = b_q[k-1];
      s_r[k] = res_q[k-1];
      s_c[k] = carry_q[k-1];
      s_v[k] = valid_q[k-1];
    end
    for (int k = 0; k < Stages; k++) begin
      sum_c[k] = {1'b0, s_a[k][k*SliceW +: SliceW]} + {1'b0, s_b[k][k*SliceW +: SliceW]}
               + {{SliceW{1'b0}}, s_c[k]};
      res_d[k] = s_r[k];
      res_d[k][k*SliceW +: SliceW] = sum_c[k][SliceW-1:0];
      carry_d[k] = sum_c[k][SliceW];
      valid_d[k] = s_v[k];
      a_d[k]     = s_a[k];
      b_d[k]     = s_b[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < Stages; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        res_q[k] <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
    end else if (adv) begin
      for (int k = 0; k < Stages; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        res_q[k] <= res_d[k];
      end
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o  = valid_q[Last];
  assign result_o = res_q[Last];
  assign carry_o  = carry_q[Last];

`ifdef PIPE_ADDER_OVF_EN
  logic ovf_q, ovf_d;

  // Sign information is complete only in the last segment, so overflow is resolved there.
  assign ovf_d = (s_a[Last][Width-1] == s_b[Last][Width-1]) &&
                 (res_d[Last][Width-1] != s_a[Last][Width-1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`endif

  logic unused_ops;
  assign unused_ops = ^{a_q[Last], b_q[Last]};

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder (Width=8, Stages=2): directed vectors, stalls, mid-flight reset.
module tb_pipe_adder;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic       sub_i = 1'b0;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic [7:0] result_o;
  logic       carry_o;
`ifdef PIPE_ADDER_OVF_EN
  logic       overflow_o;
`endif

  always #5 clk = ~clk;

  pipe_adder #(
    .Width (8),
    .Stages(2)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .sub_i     (sub_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result_o  (result_o),
`ifdef PIPE_ADDER_OVF_EN
    .overflow_o(overflow_o),
`endif
    .carry_o   (carry_o)
  );

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       ovf;
  } exp_t;

  exp_t        sb[$];
  exp_t        exp_cur;
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] ready_pat = 16'hB2E5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected response is queued at the moment the input is accepted.
  always @(negedge clk) begin
    if (rst_ni && valid_i && ready_o) sb.push_back(exp_cur);
  end

  always @(negedge clk) begin
    if (rst_ni && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", result_o);
      end else begin
        mon_e = sb.pop_front();
        chk("result", {24'd0, result_o}, {24'd0, mon_e.res});
        chk("carry", {31'd0, carry_o}, {31'd0, mon_e.c});
`ifdef PIPE_ADDER_OVF_EN
        chk("overflow", {31'd0, overflow_o}, {31'd0, mon_e.ovf});
`endif
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [7:0] res, input logic c, input logic ovf);
    a_i     = a;
    b_i     = b;
    sub_i   = sub;
    exp_cur = '{res: res, c: c, ovf: ovf};
    valid_i = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready_o) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: got ready_o=0 for 50 cycles, expected acceptance");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_ready_o", {31'd0, ready_o}, 32'd1);
    chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("rst_result_o", {24'd0, result_o}, 32'd0);
    chk("rst_carry_o", {31'd0, carry_o}, 32'd0);
    #10 rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // Cross-slice carry and exact two-cycle latency.
    send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    valid_i = 1'b0;
    @(negedge clk);
    chk("latency_early", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    chk("latency_2", {31'd0, valid_o}, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back carry/borrow/overflow vectors.
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Downstream stall from the first output: hold and no loss.
    ready_i = 1'b0;
    fork
      begin
        send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        send(8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b0);
        send(8'h03, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0);
        send(8'h04, 8'h04, 1'b0, 8'h08, 1'b0, 1'b0);
        valid_i = 1'b0;
      end
      begin
        for (int n = 0; n < 20; n++) begin
          @(negedge clk);
          if (valid_o) break;
        end
        repeat (3) begin
          chk("stall_ready_o", {31'd0, ready_o}, 32'd0);
          chk("stall_valid_o", {31'd0, valid_o}, 32'd1);
          chk("stall_result_o", {24'd0, result_o}, 32'h02);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;

    // Irregular back-pressure while streaming.
    fork
      begin
        send(8'hA5, 8'h5B, 1'b0, 8'h00, 1'b1, 1'b0);
        send(8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0);
        send(8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0);
        send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        valid_i = 1'b0;
      end
      begin
        for (int i = 0; i < 16; i++) begin
          ready_i = ready_pat[i];
          @(posedge clk);
          #1;
        end
        ready_i = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Reset with two transactions in flight.
    send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
    send(8'h44, 8'h11, 1'b0, 8'h55, 1'b0, 1'b0);
    valid_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_valid_o", {31'd0, valid_o}, 32'd0);
    chk("midrst_result_o", {24'd0, result_o}, 32'd0);
    chk("midrst_ready_o", {31'd0, ready_o}, 32'd1);
    sb.delete();
    @(negedge clk);
    #2 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
    valid_i = 1'b0;
    @(negedge clk);
    chk("postrst_early", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    chk("postrst_valid_o", {31'd0, valid_o}, 32'd1);
    chk("postrst_result_o", {24'd0, result_o}, 32'h30);

    for (int n = 0; n < 30; n++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain_pending", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
